sample_packer: RTL

- Sits directly upstream of the Ethernet packet streamer in the ADC `clk` domain.
- Takes one quantized complex sample (4-bit I, 4-bit Q) per `in_valid` cycle and truncates it to the selected bit depth.
- Packs samples MSB-first into 16-bit words.
- Emits each word as a one-cycle `source_en` pulse, and flags the last word of every fixed-length packet with `source_packet_end`.

---
 rtl/sample_packer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/sample_packer.sv
// sample_packer: truncates 4-bit I/Q samples to the selected bit depth and
// packs them MSB-first into 16-bit words. Each word is emitted as a one-cycle
// strobe, and the last word of every fixed-length packet is flagged.
// Optional feature macro: SAMPLE_PACKER_TEST_PATTERN_EN (adds test_mode; a
// latched test_mode replaces packed data with a free-running word counter).
module sample_packer #(
  parameter int unsigned PACKET_WORDS = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  in_i,
  input  logic [3:0]  in_q,
  input  logic [1:0]  mode,
  input  logic        enable,
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic [15:0] source_data,
  output logic        source_en,
  output logic        source_packet_end,
  output logic        busy
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned SCNT_W = 3;
  localparam int unsigned WCNT_W = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(PACKET_WORDS - 1);

  // Depth codes; 2'b11 is folded onto 4-bit before it is latched.
  localparam logic [1:0] M_1B = 2'b00;
  localparam logic [1:0] M_2B = 2'b01;
  localparam logic [1:0] M_4B = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          lmode_q, lmode_d;
  logic [WORD_W-1:0]   part_q, part_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [WORD_W-1:0]   source_data_q, source_data_d;
  logic                source_en_q, source_en_d;
  logic                source_packet_end_q, source_packet_end_d;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
  logic                ltest_q, ltest_d;
  logic [WORD_W-1:0]   pat_q, pat_d;
`endif

  logic [1:0]          mode_norm;
  logic [1:0]          cur_mode;
  logic                consume;
  logic                last_sample;
  logic [WORD_W-1:0]   part_base;
  logic [WORD_W-1:0]   word_nxt;

  // Fold the reserved depth code onto 4-bit.
  assign mode_norm = (mode == 2'b11) ? M_4B : mode;

  // Next-state, packing and emit logic.
  always_comb begin
    state_d             = state_q;
    lmode_d             = lmode_q;
    part_d              = part_q;
    scnt_d              = scnt_q;
    wcnt_d              = wcnt_q;
    source_data_d       = source_data_q;
    source_en_d         = 1'b0;
    source_packet_end_d = 1'b0;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
    ltest_d             = ltest_q;
    pat_d               = pat_q;
`endif
    consume             = 1'b0;
    cur_mode            = lmode_q;
    last_sample         = 1'b0;
    part_base           = '0;
    word_nxt            = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid && enable) begin
          state_d  = S_RUN;
          lmode_d  = mode_norm;
          cur_mode = mode_norm;
          consume  = 1'b1;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
          ltest_d  = test_mode;
`endif
        end
      end
      S_RUN: begin
        consume = in_valid;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (consume) begin
      // A new word starts from a clean accumulator.
      part_base = (scnt_q == '0) ? '0 : part_q;
      case (cur_mode)
        M_1B: begin
          word_nxt    = (part_base << 2) | WORD_W'({in_i[3], in_q[3]});
          last_sample = (scnt_q == SCNT_W'(7));
        end
        M_2B: begin
          word_nxt    = (part_base << 4) | WORD_W'({in_i[3:2], in_q[3:2]});
          last_sample = (scnt_q == SCNT_W'(3));
        end
        default: begin
          word_nxt    = (part_base << 8) | WORD_W'({in_i, in_q});
          last_sample = (scnt_q == SCNT_W'(1));
        end
      endcase
      part_d = word_nxt;

      if (last_sample) begin
        scnt_d      = '0;
        source_en_d = 1'b1;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
        source_data_d = ltest_q ? pat_q : word_nxt;
        pat_d         = pat_q + WORD_W'(1);
`else
        source_data_d = word_nxt;
`endif
        if (wcnt_q == LAST_WORD) begin
          source_packet_end_d = 1'b1;
          wcnt_d              = '0;
          if (enable) begin
            lmode_d = mode_norm;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
            ltest_d = test_mode;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end else begin
        scnt_d = scnt_q + SCNT_W'(1);
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= S_IDLE;
      lmode_q             <= M_1B;
      part_q              <= '0;
      scnt_q              <= '0;
      wcnt_q              <= '0;
      source_data_q       <= '0;
      source_en_q         <= 1'b0;
      source_packet_end_q <= 1'b0;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
      ltest_q             <= 1'b0;
      pat_q               <= '0;
`endif
    end else begin
      state_q             <= state_d;
      lmode_q             <= lmode_d;
      part_q              <= part_d;
      scnt_q              <= scnt_d;
      wcnt_q              <= wcnt_d;
      source_data_q       <= source_data_d;
      source_en_q         <= source_en_d;
      source_packet_end_q <= source_packet_end_d;
`ifdef SAMPLE_PACKER_TEST_PATTERN_EN
      ltest_q             <= ltest_d;
      pat_q               <= pat_d;
`endif
    end
  end

  assign source_data       = source_data_q;
  assign source_en         = source_en_q;
  assign source_packet_end = source_packet_end_q;
  assign busy              = (state_q == S_RUN);

endmodule
